// File: rtl/hbif_cmd_ctrl.sv
// UART command decoder: turns write (0x57 addr data) and read (0x52 addr) byte
// sequences into single register-bus accesses and returns one response byte.
module hbif_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 68750
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       tx_ready_i,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o,
  output logic       bus_req_o,
  output logic       bus_we_o,
  output logic [7:0] bus_addr_o,
  output logic [7:0] bus_wdata_o,
  input  logic       bus_ack_i,
  input  logic [7:0] bus_rdata_i,
  output logic [1:0] err_o
);

  localparam logic [7:0]  OP_WRITE = 8'h57;
  localparam logic [7:0]  OP_READ  = 8'h52;
  localparam logic [7:0]  RSP_OK   = 8'h4B;
  localparam logic [7:0]  RSP_BAD  = 8'h3F;
  localparam logic [19:0] TMO_MAX  = 20'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t      state, state_nxt;
  logic [19:0] tmo_cnt;
  logic        accept_op;
  logic        op_known;
  logic        tmo_hit;

  assign accept_op  = (state == IDLE) && en_i && rx_valid_i;
  assign op_known   = (rx_data_i == OP_WRITE) || (rx_data_i == OP_READ);
  // A byte arriving on the terminal count still wins over the timeout.
  assign tmo_hit    = (tmo_cnt == TMO_MAX) && !rx_valid_i;
  assign bus_req_o  = (state == BUS);
  assign tx_valid_o = (state == RESP);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: if (accept_op) state_nxt = op_known ? ADDR : RESP;
      ADDR: begin
        if (rx_valid_i)   state_nxt = bus_we_o ? DATA : BUS;
        else if (tmo_hit) state_nxt = IDLE;
      end
      DATA: begin
        if (rx_valid_i)   state_nxt = BUS;
        else if (tmo_hit) state_nxt = IDLE;
      end
      BUS:  if (bus_ack_i)  state_nxt = RESP;
      RESP: if (tx_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 8'h00;
      bus_wdata_o <= 8'h00;
      tx_data_o   <= 8'h00;
      err_o       <= 2'b00;
      tmo_cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept_op) begin
            bus_we_o <= (rx_data_i == OP_WRITE);
            tmo_cnt  <= '0;
            if (!op_known) tx_data_o <= RSP_BAD;
          end
        end
        ADDR, DATA: begin
          if (rx_valid_i) begin
            if (state == ADDR) bus_addr_o  <= rx_data_i;
            else               bus_wdata_o <= rx_data_i;
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            err_o[0] <= 1'b1;
            tmo_cnt  <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 20'd1;
          end
        end
        BUS: begin
          if (bus_ack_i)  tx_data_o <= bus_we_o ? RSP_OK : bus_rdata_i;
          if (rx_valid_i) err_o[1]  <= 1'b1;
        end
        RESP: if (rx_valid_i) err_o[1] <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
